al_seg_scan: RTL and testbench



---
 rtl/al_seg_scan.sv | 113 +++++++++++
 tb/tb_al_seg_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/al_seg_scan.sv
// Six-digit multiplexed scanner for the alarm-clock display.
// It snapshots the time once per frame and drives one digit per slot, with a blanking gap, blink, leading-zero and dot handling.
module al_seg_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 50,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] TIME_BCD,
  input  logic [5:0]  BLINK_MASK,
  input  logic        ALARM_ON,
  output logic [3:0]  BCD,
  output logic        SEG_DOT,
  output logic [5:0]  DIGIT_SEL
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_BLANK = DW'(BLANK_CYC);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0] div_reg, div_next;
  logic [2:0]    idx_reg, idx_next;
  logic [FW-1:0] frm_reg, frm_next;
  logic          ph_reg, ph_next;
  logic [23:0]   snap_reg, snap_next;
  logic          slot_end, frame_end;

  logic [5:0]    sel_next;
  logic [3:0]    bcd_next;
  logic          dot_next;
  logic [3:0]    nib [0:5];
  logic [3:0]    cur_nib;

  always_comb begin
    slot_end  = (div_reg == DIV_LAST);
    frame_end = slot_end && (idx_reg == 3'd5);
    div_next  = slot_end ? '0 : div_reg + 1'b1;
    idx_next  = idx_reg;
    frm_next  = frm_reg;
    ph_next   = ph_reg;
    snap_next = snap_reg;
    if (slot_end) begin
      idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end
    if (frame_end) begin
      snap_next = TIME_BCD;
      if (frm_reg == FRM_LAST) begin
        frm_next = '0;
        ph_next  = ~ph_reg;
      end else begin
        frm_next = frm_reg + 1'b1;
      end
    end
  end

  // Digit 0 is the most significant nibble (hour tens).
  for (genvar gi = 0; gi < 6; gi++) begin : g_nib
    assign nib[gi] = snap_next[23-4*gi -: 4];
  end

  // Outputs are computed from the next-state counters so the flops line up with the counters.
  always_comb begin
    sel_next = 6'b000000;
    bcd_next = 4'hF;
    dot_next = 1'b0;
    cur_nib  = nib[0];
    if (idx_next <= 3'd5) begin
      cur_nib = nib[idx_next];
    end
    if (div_next >= DIV_BLANK) begin
      sel_next = 6'b000001 << idx_next;
      bcd_next = cur_nib;
      if (ph_next && BLINK_MASK[idx_next]) begin
        bcd_next = 4'hF;
      end
      if (LZ_BLANK && (idx_next == 3'd0) && (cur_nib == 4'h0)) begin
        bcd_next = 4'hF;
      end
      case (idx_next)
        3'd1, 3'd3: dot_next = 1'b1;
        3'd5:       dot_next = ALARM_ON;
        default:    dot_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_reg   <= '0;
      idx_reg   <= 3'd0;
      frm_reg   <= '0;
      ph_reg    <= 1'b0;
      snap_reg  <= 24'h000000;
      DIGIT_SEL <= 6'b000000;
      BCD       <= 4'hF;
      SEG_DOT   <= 1'b0;
    end else begin
      div_reg   <= div_next;
      idx_reg   <= idx_next;
      frm_reg   <= frm_next;
      ph_reg    <= ph_next;
      snap_reg  <= snap_next;
      DIGIT_SEL <= sel_next;
      BCD       <= bcd_next;
      SEG_DOT   <= dot_next;
    end
  end

endmodule

// File: tb/tb_al_seg_scan.sv
// Scoreboard bench for al_seg_scan: stimulus queues the expected first active cycle of each digit slot.
// One monitor per instance pops and compares each entry when a slot lights up.
module tb_al_seg_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_lz;
  logic [23:0] time_bcd, time_lz;
  logic [5:0]  blink_mask, mask_lz;
  logic        alarm_on, alarm_lz;
  logic [3:0]  bcd, bcd_lz;
  logic        seg_dot, dot_lz;
  logic [5:0]  digit_sel, sel_lz;

  al_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .LZ_BLANK(1'b0)) u_dut (
    .CLK(clk), .RST(rst), .TIME_BCD(time_bcd), .BLINK_MASK(blink_mask),
    .ALARM_ON(alarm_on), .BCD(bcd), .SEG_DOT(seg_dot), .DIGIT_SEL(digit_sel)
  );

  al_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .LZ_BLANK(1'b1)) u_lz (
    .CLK(clk), .RST(rst_lz), .TIME_BCD(time_lz), .BLINK_MASK(mask_lz),
    .ALARM_ON(alarm_lz), .BCD(bcd_lz), .SEG_DOT(dot_lz), .DIGIT_SEL(sel_lz)
  );

  typedef struct packed {
    logic [5:0] sel;
    logic [3:0] bcd;
    logic       dot;
  } exp_t;

  exp_t q_main[$];
  exp_t q_lz[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_frame(input bit to_lz, input logic [23:0] bcds, input logic [5:0] dots, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.sel = 6'(1 << i);
      e.bcd = bcds[23-4*i -: 4];
      e.dot = dots[i];
      if (to_lz) q_lz.push_back(e);
      else       q_main.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: a slot is presented when DIGIT_SEL goes from all-off to non-zero.
  logic [5:0] prev_main = 6'b0;
  int         slot_main = 0;
  always @(negedge clk) begin
    if (digit_sel != 6'b0 && prev_main == 6'b0) begin
      n_cmp++;
      if (q_main.size() == 0) begin
        n_bad++;
        $display("FAIL main_unexpected_slot: got sel=%b bcd=%h dot=%b expected no slot", digit_sel, bcd, seg_dot);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        if ({digit_sel, bcd, seg_dot} !== e) begin
          n_bad++;
          $display("FAIL main_slot%0d: got sel=%b bcd=%h dot=%b expected sel=%b bcd=%h dot=%b",
                   slot_main, digit_sel, bcd, seg_dot, e.sel, e.bcd, e.dot);
        end else begin
          $display("main slot %0d: sel=%b bcd=%h dot=%b ok", slot_main, digit_sel, bcd, seg_dot);
        end
      end
      slot_main++;
    end
    prev_main = digit_sel;
  end

  logic [5:0] prev_lz = 6'b0;
  int         slot_lz = 0;
  always @(negedge clk) begin
    if (sel_lz != 6'b0 && prev_lz == 6'b0) begin
      n_cmp++;
      if (q_lz.size() == 0) begin
        n_bad++;
        $display("FAIL lz_unexpected_slot: got sel=%b bcd=%h dot=%b expected no slot", sel_lz, bcd_lz, dot_lz);
      end else begin
        exp_t e;
        e = q_lz.pop_front();
        if ({sel_lz, bcd_lz, dot_lz} !== e) begin
          n_bad++;
          $display("FAIL lz_slot%0d: got sel=%b bcd=%h dot=%b expected sel=%b bcd=%h dot=%b",
                   slot_lz, sel_lz, bcd_lz, dot_lz, e.sel, e.bcd, e.dot);
        end else begin
          $display("lz slot %0d: sel=%b bcd=%h dot=%b ok", slot_lz, sel_lz, bcd_lz, dot_lz);
        end
      end
      slot_lz++;
    end
    prev_lz = sel_lz;
  end

  initial begin
    rst        = 1'b1;
    rst_lz     = 1'b1;
    time_bcd   = 24'h123456;
    blink_mask = 6'b000000;
    alarm_on   = 1'b0;
    time_lz    = 24'h093000;
    mask_lz    = 6'b000000;
    alarm_lz   = 1'b1;
    step(3);
    check("reset_sel", 32'(digit_sel), 32'h0);
    check("reset_bcd", 32'(bcd), 32'hF);
    check("reset_dot", 32'(seg_dot), 32'h0);

    // Frame 0 shows the reset snapshot of zero; the LZ instance blanks hour tens.
    push_frame(1'b0, 24'h000000, 6'b001010, 6);
    push_frame(1'b1, 24'hF00000, 6'b101010, 6);
    push_frame(1'b1, 24'hF93000, 6'b101010, 6);
    push_frame(1'b1, 24'h103000, 6'b101010, 6);
    rst    = 1'b0;
    rst_lz = 1'b0;

    step(1);  // k=1
    check("k1_gap_sel", 32'(digit_sel), 32'h0);
    step(1);  // k=2
    check("k2_sel", 32'(digit_sel), 32'h01);
    check("k2_bcd", 32'(bcd), 32'h0);
    push_frame(1'b0, 24'h123456, 6'b001010, 6);
    step(6);  // k=8
    check("k8_gap_sel", 32'(digit_sel), 32'h0);

    step(52); // k=60: mid-frame change must not tear frame 1
    time_bcd = 24'h235959;
    time_lz  = 24'h103000;
    push_frame(1'b0, 24'h235959, 6'b101010, 6);
    step(36); // k=96
    alarm_on = 1'b1;
    step(4);  // k=100
    time_bcd = 24'h123456;
    step(44); // k=144: blink phase is 1 in frame 3, 0 in frames 4-5
    alarm_on   = 1'b0;
    blink_mask = 6'b000011;
    rst_lz     = 1'b1;
    push_frame(1'b0, 24'hFF3456, 6'b001010, 6);
    push_frame(1'b0, 24'h123456, 6'b001010, 6);
    push_frame(1'b0, 24'h123456, 6'b001010, 4);

    step(125); // k=269: IDX=3, DIV=5
    rst = 1'b1;
    #1;
    check("midrst_sel", 32'(digit_sel), 32'h0);
    check("midrst_bcd", 32'(bcd), 32'hF);
    check("midrst_dot", 32'(seg_dot), 32'h0);
    time_bcd   = 24'h987654;
    blink_mask = 6'b000000;
    step(2);
    push_frame(1'b0, 24'h000000, 6'b001010, 6);
    push_frame(1'b0, 24'h987654, 6'b001010, 6);
    rst = 1'b0;
    step(2);
    check("restart_k2_sel", 32'(digit_sel), 32'h01);
    check("restart_k2_bcd", 32'(bcd), 32'h0);
    step(94);
    rst = 1'b1;
    step(2);
    check("main_queue_drained", 32'(q_main.size()), 32'h0);
    check("lz_queue_drained", 32'(q_lz.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
